// File: rtl/tff_toggle_decoder.sv
// Recovers discrete events from a toggle-encoded level: every change of i_q_in after arming
// becomes a one-cycle pulse, is counted, and is queued for a valid/ready consumer.
module tff_toggle_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int DEPTH       = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_q_in,
  input  logic             i_clr,
  input  logic             i_evt_ready,
  output logic             o_level,
  output logic             o_pulse_out,
  output logic             o_evt_valid,
  output logic [3:0]       o_pending,
  output logic [CNT_W-1:0] o_evt_cnt,
  output logic             o_cnt_sat,
  output logic             o_ovf
);

  typedef enum logic {ST_UNARMED, ST_ARMED} state_t;

  localparam logic [3:0]       DEPTH_C  = 4'(DEPTH);
  localparam logic [2:0]       STAGES_C = 3'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_MAX - CNT_W'(1);

  state_t                 r_state;
  logic [2:0]             r_stage;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ref;
  logic                   r_pulse;
  logic                   r_valid;
  logic [3:0]             r_pending;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_sat;
  logic                   r_ovf;

  logic w_level;
  logic w_detect;
  logic w_consume;

  assign w_level   = r_sync[SYNC_STAGES-1];
  assign w_detect  = (r_state == ST_ARMED) && (w_level != r_ref);
  assign w_consume = r_valid && i_evt_ready;

  assign o_level     = w_level;
  assign o_pulse_out = r_pulse;
  assign o_evt_valid = r_valid;
  assign o_pending   = r_pending;
  assign o_evt_cnt   = r_cnt;
  assign o_cnt_sat   = r_sat;
  assign o_ovf       = r_ovf;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_q_in};
    end
  end

  // Arming waits until the sync chain holds real samples, so the first level is a reference only.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_UNARMED;
      r_stage <= '0;
      r_ref   <= 1'b0;
    end else if (r_state == ST_UNARMED) begin
      if (r_stage == STAGES_C) begin
        r_ref   <= w_level;
        r_state <= ST_ARMED;
      end else begin
        r_stage <= r_stage + 3'd1;
      end
    end else begin
      r_ref <= w_level;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_pulse   <= 1'b0;
      r_valid   <= 1'b0;
      r_pending <= '0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (i_clr) begin
      // A detect in this cycle is dropped; ref still follows level so it is not seen again.
      r_pulse   <= 1'b0;
      r_valid   <= 1'b0;
      r_pending <= '0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_pulse <= w_detect;
      if (w_detect && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_TOP) begin
          r_sat <= 1'b1;
        end
      end
      if (w_detect && !w_consume) begin
        if (r_pending == DEPTH_C) begin
          r_ovf <= 1'b1;
        end else begin
          r_pending <= r_pending + 4'd1;
          r_valid   <= 1'b1;
        end
      end else if (w_consume && !w_detect) begin
        r_pending <= r_pending - 4'd1;
        r_valid   <= (r_pending != 4'd1);
      end
    end
  end

endmodule

// File: tb/tb_tff_toggle_decoder.sv
// Bench for tff_toggle_decoder: two instances (8-bit and 3-bit counters) share stimulus and are
// checked every cycle against a sample-history model, plus literal checks per scenario.
`timescale 1ns/100ps
module tb_tff_toggle_decoder;

  localparam int S     = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic q_in = 1'b1;
  logic clr = 1'b0;
  logic evt_ready = 1'b0;

  logic       level_a, pulse_a, valid_a, sat_a, ovf_a;
  logic [3:0] pend_a;
  logic [7:0] cnt_a;
  logic       level_b, pulse_b, valid_b, sat_b, ovf_b;
  logic [3:0] pend_b;
  logic [2:0] cnt_b;

  int errors = 0;
  int checks = 0;
  int pulse_total = 0;
  int max_pend = 0;

  always #3 clk = ~clk;

  tff_toggle_decoder #(.SYNC_STAGES(S), .CNT_W(8), .DEPTH(DEPTH)) u_dut (
    .i_clk(clk), .i_rstn(rstn), .i_q_in(q_in), .i_clr(clr), .i_evt_ready(evt_ready),
    .o_level(level_a), .o_pulse_out(pulse_a), .o_evt_valid(valid_a), .o_pending(pend_a),
    .o_evt_cnt(cnt_a), .o_cnt_sat(sat_a), .o_ovf(ovf_a)
  );

  tff_toggle_decoder #(.SYNC_STAGES(S), .CNT_W(3), .DEPTH(DEPTH)) u_dut3 (
    .i_clk(clk), .i_rstn(rstn), .i_q_in(q_in), .i_clr(clr), .i_evt_ready(evt_ready),
    .o_level(level_b), .o_pulse_out(pulse_b), .o_evt_valid(valid_b), .o_pending(pend_b),
    .o_evt_cnt(cnt_b), .o_cnt_sat(sat_b), .o_ovf(ovf_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: q_in is sampled at every edge since reset release; level after edge n is the sample
  // of edge n-S+1, and an event is reported at edge n when consecutive level samples differ.
  logic hist[$];
  int   n_edges = 0;
  logic m_level = 0, m_pulse = 0, m_valid = 0, m_sat8 = 0, m_sat3 = 0, m_ovf = 0;
  int   m_pend = 0, m_cnt8 = 0, m_cnt3 = 0;

  task automatic model_reset();
    n_edges = 0;
    hist.delete();
    m_level = 0; m_pulse = 0; m_valid = 0; m_sat8 = 0; m_sat3 = 0; m_ovf = 0;
    m_pend = 0; m_cnt8 = 0; m_cnt3 = 0;
  endtask

  task automatic model_step();
    logic cons;
    logic det;
    cons = (m_pend != 0) && evt_ready;
    n_edges++;
    hist.push_back(q_in);
    m_level = (n_edges >= S) ? hist[n_edges-S] : 1'b0;
    det = (n_edges >= S + 2) && (hist[n_edges-S-1] != hist[n_edges-S-2]);
    if (clr) begin
      m_pulse = 0; m_pend = 0; m_cnt8 = 0; m_cnt3 = 0; m_sat8 = 0; m_sat3 = 0; m_ovf = 0;
    end else begin
      m_pulse = det;
      if (det) begin
        if (m_cnt8 < 255) begin m_cnt8++; if (m_cnt8 == 255) m_sat8 = 1; end
        if (m_cnt3 < 7)   begin m_cnt3++; if (m_cnt3 == 7)   m_sat3 = 1; end
      end
      if (det && !cons) begin
        if (m_pend == DEPTH) m_ovf = 1;
        else m_pend++;
      end else if (cons && !det) begin
        m_pend--;
      end
    end
    m_valid = (m_pend != 0);
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    chk("cyc_level",   int'(level_a), int'(m_level));
    chk("cyc_pulse",   int'(pulse_a), int'(m_pulse));
    chk("cyc_valid",   int'(valid_a), int'(m_valid));
    chk("cyc_pending", int'(pend_a),  m_pend);
    chk("cyc_cnt8",    int'(cnt_a),   m_cnt8);
    chk("cyc_sat8",    int'(sat_a),   int'(m_sat8));
    chk("cyc_ovf",     int'(ovf_a),   int'(m_ovf));
    chk("cyc_pulse3",  int'(pulse_b), int'(m_pulse));
    chk("cyc_cnt3",    int'(cnt_b),   m_cnt3);
    chk("cyc_sat3",    int'(sat_b),   int'(m_sat3));
    chk("cyc_pend3",   int'(pend_b),  m_pend);
    chk("cyc_ovf3",    int'(ovf_b),   int'(m_ovf));
    chk("cyc_valid3",  int'(valid_b), int'(m_valid));
    chk("cyc_level3",  int'(level_b), int'(m_level));
    if (pulse_a) pulse_total++;
    if (int'(pend_a) > max_pend) max_pend = int'(pend_a);
  end

  initial begin
    int base;
    int ones;
    int t;
    logic q;

    // Arming with q_in held high through reset and release
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("arm_pulses", pulse_total, 0);
    chk("arm_cnt", int'(cnt_a), 0);
    chk("arm_pending", int'(pend_a), 0);
    chk("arm_level", int'(level_a), 1);
    $display("arming: cnt=%0d pending=%0d pulses=%0d", cnt_a, pend_a, pulse_total);

    // Single toggle 1->0: pulse appears after the third sampling edge
    @(negedge clk);
    q_in = 1'b0;
    @(negedge clk); chk("st_e1_pulse", int'(pulse_a), 0);
    @(negedge clk); chk("st_e2_pulse", int'(pulse_a), 0); chk("st_e2_level", int'(level_a), 0);
    @(negedge clk); chk("st_e3_pulse", int'(pulse_a), 1);
    @(negedge clk); chk("st_e4_pulse", int'(pulse_a), 0);
    chk("st_cnt", int'(cnt_a), 1);
    chk("st_pending", int'(pend_a), 1);
    chk("st_valid", int'(valid_a), 1);
    $display("single toggle: cnt=%0d pending=%0d valid=%0d", cnt_a, pend_a, valid_a);

    // Random toggle-FF stream, changes every 7 ns, never on a clock edge
    evt_ready = 1'b1;
    @(negedge clk);
    #1;
    base = pulse_total;
    max_pend = 0;
    ones = 0;
    q = q_in;
    #0.5;
    for (int i = 0; i < 21; i++) begin
      t = int'($urandom_range(0, 1));
      if (t == 1) begin q = ~q; ones++; end
      q_in = q;
      #7;
    end
    repeat (6) @(negedge clk);
    #1;
    chk("rand_pulses", pulse_total - base, ones);
    chk("rand_pending_le1", int'(max_pend <= 1), 1);
    chk("rand_ovf", int'(ovf_a), 0);
    $display("random stream: t_ones=%0d pulses=%0d max_pending=%0d", ones, pulse_total - base, max_pend);

    // Overflow with consumer stalled
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      q_in = ~q_in;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("ovf_pending", int'(pend_a), 4);
    chk("ovf_flag", int'(ovf_a), 1);
    chk("ovf_cnt", int'(cnt_a), 6);
    $display("overflow: pending=%0d ovf=%0d cnt=%0d", pend_a, ovf_a, cnt_a);
    evt_ready = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      @(negedge clk);
      chk("drain_pending", int'(pend_a), k);
    end
    chk("drain_valid", int'(valid_a), 0);
    $display("drain: pending=%0d valid=%0d", pend_a, valid_a);

    // Saturation of the 3-bit counter, then clear colliding with a detect
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      q_in = ~q_in;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("sat_cnt3", int'(cnt_b), 7);
    chk("sat_flag3", int'(sat_b), 1);
    chk("sat_cnt8", int'(cnt_a), 9);
    chk("sat_flag8", int'(sat_a), 0);
    $display("saturation: cnt3=%0d sat3=%0d cnt8=%0d", cnt_b, sat_b, cnt_a);
    q_in = ~q_in;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_pulse", int'(pulse_a), 0);
    chk("clr_cnt3", int'(cnt_b), 0);
    chk("clr_sat3", int'(sat_b), 0);
    chk("clr_cnt8", int'(cnt_a), 0);
    #1;
    base = pulse_total;
    repeat (6) @(negedge clk);
    #1;
    chk("clr_no_late_pulse", pulse_total - base, 0);
    chk("clr_cnt_stays", int'(cnt_a), 0);
    $display("clear with detect: cnt8=%0d cnt3=%0d", cnt_a, cnt_b);

    // Asynchronous reset mid-cycle with two events pending
    evt_ready = 1'b0;
    q_in = ~q_in;
    @(negedge clk);
    q_in = ~q_in;
    repeat (5) @(negedge clk);
    chk("rst_pre_pending", int'(pend_a), 2);
    #1.5;
    rstn = 1'b0;
    #0.5;
    chk("rst_level", int'(level_a), 0);
    chk("rst_pulse", int'(pulse_a), 0);
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_pending", int'(pend_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    chk("rst_sat", int'(sat_a), 0);
    chk("rst_ovf", int'(ovf_a), 0);
    chk("rst_cnt3", int'(cnt_b), 0);
    q_in = ~q_in;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    base = pulse_total;
    repeat (10) @(negedge clk);
    #1;
    chk("rearm_pulses", pulse_total - base, 0);
    chk("rearm_cnt", int'(cnt_a), 0);
    chk("rearm_level", int'(level_a), int'(q_in));
    q_in = ~q_in;
    repeat (4) @(negedge clk);
    chk("rearm_toggle_cnt", int'(cnt_a), 1);
    $display("reset mid-op: rearmed cnt=%0d pending=%0d", cnt_a, pend_a);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tff_toggle_decoder.md
# tff_toggle_decoder

Receive-side counterpart of the toggle flip-flop: recovers the original T-pulse stream from a toggle-encoded level (`q_in`), where every change of `q_in` represents one event. `q_in` is synchronized, the first post-reset level is taken as reference without generating an event, and every later change becomes a one-cycle pulse. Each event is counted, and pending events are buffered for a valid/ready consumer. It sits wherever a TFF output crosses into logic that needs discrete events back.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops on `q_in`. Legal values are 2 to 4.
- `CNT_W`, default 8: width of the event counter.
- `DEPTH`, default 4: maximum number of pending (unconsumed) events. Legal values are 1 to 15.
- `clk` in 1: single clock. All logic runs on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `q_in` in 1: toggle-encoded event line. It may be asynchronous to `clk`.
- `clr` in 1: synchronous clear of the counter, flags and pending events.
- `evt_ready` in 1: consumer accepts one event.
- `level` out 1: synchronized `q_in`, taken from the last sync stage.
- `pulse_out` out 1: one-cycle pulse per detected toggle.
- `evt_valid` out 1: at least one event is pending.
- `pending` out 4: number of pending events, from 0 to `DEPTH`.
- `evt_cnt` out `CNT_W`: total detected toggles. Saturates at all-ones.
- `cnt_sat` out 1: sticky; `evt_cnt` has saturated.
- `ovf` out 1: sticky; an event arrived while the pending buffer was full.

## Operation
- **Reset values.** Under reset, all outputs are 0, the sync chain is 0, the reference flop `ref` is 0, and the FSM is in UNARMED.
- **FSM.**
  - UNARMED: a stage counter counts `SYNC_STAGES` edges after `rstn` deasserts. At the next edge, `ref` <= `level` and the FSM moves to ARMED. No events are generated in UNARMED, whatever value `q_in` holds.
  - ARMED: on each edge, a detect fires if `level != ref`, and then `ref` <= `level`.
  - The FSM leaves ARMED only through reset. `clr` does not change the FSM state.
- **Detect.** A detect causes three things at the same edge:
  - `pulse_out` is 1 for the following cycle.
  - `evt_cnt` increments, unless it is already all-ones. If the increment reaches all-ones, `cnt_sat` sets.
  - `pending` is updated according to the buffer rules below.
- **Pending buffer.**
  - `evt_valid = (pending != 0)`.
  - A consume occurs when `evt_valid && evt_ready` at an edge.
  - detect only: `pending` +1. If `pending` was already `DEPTH`, it stays at `DEPTH`, `ovf` sets, and the event is dropped from the buffer but still counted in `evt_cnt`.
  - consume only: `pending` -1.
  - detect and consume together: `pending` unchanged, and `ovf` does not set even when full.
  - `evt_ready` while `evt_valid` = 0 has no effect.
- **Clear.** When `clr` = 1 at an edge:
  - `evt_cnt`, `cnt_sat`, `ovf` and `pending` go to 0, and `pulse_out` is 0 next cycle.
  - A detect in the same cycle is discarded entirely, but `ref` still updates, so the event is not re-detected later.
  - `clr` overrides any consume in the same cycle.
- **Reset mid-operation.** Asynchronous reset returns everything to the reset values immediately. After release the block re-arms from scratch, so the current `q_in` level becomes the new reference and is not reported as an event.

## Timing
- Edge numbering: E1 is the first rising edge that samples a new `q_in` value (setup met).
- `level` changes at E`SYNC_STAGES`.
- `pulse_out`, `evt_cnt`, `pending` and `evt_valid` update at E`SYNC_STAGES+1`. With defaults this gives a latency of 3 edges.
- `q_in` toggling on every cycle (stable for at least one full cycle each time) produces a pulse on every cycle. Toggles narrower than one cycle may be merged or lost; this is a documented input restriction, not detected.
- `evt_valid` may fall in the same cycle as the consuming edge only when `pending` goes 1->0. It never depends combinationally on `evt_ready`.
- ARMED is reached at the (`SYNC_STAGES`+1)-th edge after `rstn` deasserts.

## Test plan
- **Arming:** hold `q_in` = 1 through reset and release, then wait 10 cycles.
  - Required: no `pulse_out`, `evt_cnt` = 0, `pending` = 0.
- **Single toggle:** while ARMED, set `q_in` 1->0.
  - Required: `pulse_out` high for exactly one cycle, 3 edges after the sampling edge; `evt_cnt` = 1; `pending` = 1; `evt_valid` = 1.
- **Random stream:** drive 21 random `t` values into the toggle flip-flop under test (7 ns spacing), feed its `q` to `q_in`, and hold `evt_ready` = 1.
  - Required: pulse count equals the number of `t` = 1 samples that toggled `q`; `pending` never exceeds 1; `ovf` = 0.
- **Overflow:** hold `evt_ready` = 0 and apply 6 toggles (`DEPTH` = 4).
  - Required: `pending` = 4, `ovf` = 1, `evt_cnt` = 6.
  - Then raise `evt_ready` for 4 cycles. Required: `pending` counts 3, 2, 1, 0 and `evt_valid` drops.
- **Saturation and clear:** with `CNT_W` = 3, apply 9 toggles.
  - Required: `evt_cnt` = 7, `cnt_sat` = 1.
  - Then pulse `clr` in the same cycle as a detect. Required: `evt_cnt` = 0, `cnt_sat` = 0, `pulse_out` = 0, and no later spurious pulse.
- **Reset mid-operation:** with `pending` = 2, assert `rstn` = 0 asynchronously mid-cycle.
  - Required: all outputs are 0 immediately, and the block re-arms without generating an event.
